seq_divider: RTL and testbench

Iterative 64-bit integer divide/remainder unit for the RV64M DIV, DIVU, REM and REMU instructions. It sits in the Execute stage beside the combinational ALU ops, and is the inverse counterpart of the add/shift datapath. It takes operands through a start/done handshake and produces one quotient bit per cycle using restoring division. Divide-by-zero and signed overflow follow the RISC-V results exactly.

---
 rtl/seq_divider.sv | 176 +++++++++++++++++
 tb/tb_seq_divider.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative 64-bit restoring divider for RV64M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [63:0] rd,
  output logic        zero_flag,
  output logic        div_by_zero,
  output logic        overflow_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        sdiff_q, sdiff_d;
  logic        rs1neg_q, rs1neg_d;
  logic        special_q, special_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;
  logic [63:0] dvd_q, dvd_d;
  logic [63:0] dvs_q, dvs_d;
  logic [63:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] rd_q, rd_d;
  logic        zero_q, zero_d;
  logic        dbzf_q, dbzf_d;
  logic        ovff_q, ovff_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic        neg1, neg2;
  logic [64:0] rem_sh;
  logic [64:0] trial;
  logic [63:0] q_fix, r_fix, res;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sdiff_d   = sdiff_q;
    rs1neg_d  = rs1neg_q;
    special_d = special_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    zero_d    = zero_q;
    dbzf_d    = dbzf_q;
    ovff_d    = ovff_q;
    done_d    = 1'b0;

    signed_op = ~op[0];
    neg1      = signed_op & rs1[63];
    neg2      = signed_op & rs2[63];
    rem_sh    = {rem_q, dvd_q[63]};
    // rem_sh < 2*divisor, so the 65-bit difference never wraps and bit 64 is its sign
    trial     = rem_sh - {1'b0, dvs_q};
    q_fix     = dvd_q;
    r_fix     = rem_q;
    res       = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          sdiff_d  = neg1 ^ neg2;
          rs1neg_d = neg1;
          cnt_d    = 6'd63;
          rem_d    = '0;
          dvs_d    = neg2 ? -rs2 : rs2;
          if (rs2 == '0) begin
            dvd_d     = '1;
            rem_d     = rs1;
            dbz_d     = 1'b1;
            ovf_d     = 1'b0;
            special_d = 1'b1;
            state_d   = SIGN;
          end else if (signed_op && rs1 == INT_MIN && rs2 == '1) begin
            dvd_d     = rs1;
            dbz_d     = 1'b0;
            ovf_d     = 1'b1;
            special_d = 1'b1;
            state_d   = SIGN;
          end else begin
            dvd_d     = neg1 ? -rs1 : rs1;
            dbz_d     = 1'b0;
            ovf_d     = 1'b0;
            special_d = 1'b0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        // quotient bits shift into the vacated low end of the dividend register
        dvd_d = {dvd_q[62:0], ~trial[64]};
        if (!trial[64]) rem_d = trial[63:0];
        else            rem_d = rem_sh[63:0];
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == '0) state_d = SIGN;
      end
      SIGN: begin
        if (!special_q && op_q == 2'b00 && sdiff_q)  q_fix = -dvd_q;
        if (!special_q && op_q == 2'b10 && rs1neg_q) r_fix = -rem_q;
        res     = op_q[1] ? r_fix : q_fix;
        rd_d    = res;
        zero_d  = (res == '0);
        dbzf_d  = dbz_q;
        ovff_d  = ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      sdiff_q   <= 1'b0;
      rs1neg_q  <= 1'b0;
      special_q <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      zero_q    <= 1'b0;
      dbzf_q    <= 1'b0;
      ovff_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sdiff_q   <= sdiff_d;
      rs1neg_q  <= rs1neg_d;
      special_q <= special_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      zero_q    <= zero_d;
      dbzf_q    <= dbzf_d;
      ovff_q    <= ovff_d;
      done_q    <= done_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign rd            = rd_q;
  assign zero_flag     = zero_q;
  assign div_by_zero   = dbzf_q;
  assign overflow_flag = ovff_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed RV64M corner cases plus
// randomized operations checked against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic        busy, done;
  logic [63:0] rd;
  logic        zero_flag, div_by_zero, overflow_flag;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  seq_divider dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .op            (op),
    .rs1           (rs1),
    .rs2           (rs2),
    .busy          (busy),
    .done          (done),
    .rd            (rd),
    .zero_flag     (zero_flag),
    .div_by_zero   (div_by_zero),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain arithmetic.
  task automatic model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic [2:0] fl, output int lat);
    logic [63:0] q, m;
    logic dz, ov;
    longint sa, sb;
    sa = a; sb = b;
    dz = 1'b0; ov = 1'b0;
    if (b == 64'd0) begin
      q = ALL; m = a; dz = 1'b1;
    end else if (!o[0] && a == MIN && b == ALL) begin
      q = a; m = 64'd0; ov = 1'b1;
    end else if (!o[0]) begin
      q = sa / sb; m = sa % sb;
    end else begin
      q = a / b; m = a % b;
    end
    r   = o[1] ? m : q;
    fl  = {r == 64'd0, dz, ov};
    lat = (dz || ov) ? 1 : 65;
  endtask

  task automatic launch(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy after accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [63:0] exp_rd, input logic [2:0] exp_fl);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (busy == done) viol++;
      if (done) seen = 1;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " rd"}, rd, exp_rd);
    check({tag, " flags"}, {61'd0, zero_flag, div_by_zero, overflow_flag}, {61'd0, exp_fl});
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp_rd, input logic [2:0] exp_fl,
                     input int exp_lat);
    launch(o, a, b);
    wait_done(tag, exp_lat, exp_rd, exp_fl);
  endtask

  initial begin
    logic [63:0] er, a, b;
    logic [2:0]  ef;
    int          el;
    int          mode;
    logic [1:0]  o;

    #22;
    check("reset outs", {58'd0, busy, done, zero_flag, div_by_zero, overflow_flag, 1'b0}, 64'd0);
    check("reset rd", rd, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("divu 100/7", 2'b01, 64'd100, 64'd7, 64'd14, 3'b000, 65);
    repeat (3) @(posedge clk);
    #1 check("rd hold", rd, 64'd14);
    run("remu 100/7", 2'b11, 64'd100, 64'd7, 64'd2, 3'b000, 65);
    run("div -7/2", 2'b00, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 3'b000, 65);
    run("rem -7/2", 2'b10, -64'd7, 64'd2, ALL, 3'b000, 65);
    run("rem 7/-2", 2'b10, 64'd7, -64'd2, 64'd1, 3'b000, 65);
    run("div -8/-2", 2'b00, -64'd8, -64'd2, 64'd4, 3'b000, 65);
    run("divu 5/0", 2'b01, 64'd5, 64'd0, ALL, 3'b010, 1);
    run("remu 5/0", 2'b11, 64'd5, 64'd0, 64'd5, 3'b010, 1);
    run("div ovf", 2'b00, MIN, ALL, MIN, 3'b001, 1);
    run("rem ovf", 2'b10, MIN, ALL, 64'd0, 3'b101, 1);
    run("divu min/-1", 2'b01, MIN, ALL, 64'd0, 3'b100, 65);

    // start during CALC must be ignored
    launch(2'b01, 64'd1000, 64'd10);
    repeat (10) @(posedge clk);
    #1;
    op = 2'b00; rs1 = 64'd77; rs2 = 64'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored start", 54, 64'd100, 3'b000);
    // back-to-back: start raised in the done cycle
    launch(2'b11, 64'd1000, 64'd7);
    wait_done("back to back", 65, 64'd6, 3'b000);

    // reset mid-operation
    launch(2'b01, 64'd100, 64'd7);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid reset busy/done", {62'd0, busy, done}, 64'd0);
    check("mid reset rd", rd, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run("divu max/3", 2'b01, ALL, 64'd3, 64'h5555_5555_5555_5555, 3'b000, 65);

    for (int i = 0; i < 40; i++) begin
      o    = 2'($urandom_range(0, 3));
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom} >> $urandom_range(0, 63);
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 64'd0;
      if (mode == 1) begin a = MIN; b = ALL; end
      if (mode == 2) b = 64'($urandom_range(1, 9));
      if (mode == 3) b = -b;
      model(o, a, b, er, ef, el);
      run($sformatf("rand%0d op%0d", i, o), o, a, b, er, ef, el);
    end

    check("busy xor done", 64'(viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
